// File: rtl/syscall_ctrl.sv
// Syscall sequencing controller for the 5-stage pipeline.
// Detects a syscall retiring in WB, flushes younger instructions, freezes the
// pipeline while the console message is handed off, then resumes at pc+4 or
// halts the core for good.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal execution, watching WB for a syscall
// S_ISSUE | console message presented, waiting for acceptance/timeout
// S_DRAIN | post-acceptance stall window before resuming fetch
// S_HALT  | exit service taken; core frozen until reset
module syscall_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 0,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_valid,
  input  logic               wb_is_syscall,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_v0,
  input  logic [31:0]        wb_a0,
  input  logic               console_ready,
  output logic               console_valid,
  output logic [1:0]         console_kind,
  output logic [31:0]        console_data,
  output logic               stall_req,
  output logic               flush_req,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               halted,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] syscall_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HALT} state_t;

  // Drain counter runs DRAIN_CYCLES-1 down to 0; wait counter runs 0 up to TIMEOUT-1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
  localparam logic [TW-1:0] WAIT_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [31:0]   cap_v0, cap_a0, cap_pc4;
  logic [DW-1:0] drain_cnt;
  logic [TW-1:0] wait_cnt;
  logic          detect, accept, expire, msg_done, is_exit, redirect_set;
  logic [1:0]    kind_c;
  logic [31:0]   data_c;

  assign detect   = (state == S_IDLE) && wb_valid && wb_is_syscall && !rst;
  assign accept   = (state == S_ISSUE) && console_ready;
  // Acceptance in the expiry cycle wins, so expiry requires !console_ready.
  assign expire   = (TIMEOUT > 0) && (state == S_ISSUE) && !console_ready &&
                    (wait_cnt == WAIT_LAST);
  assign msg_done = accept || expire;
  assign is_exit  = (cap_v0 == 32'd10);

  assign flush_req     = detect;
  assign stall_req     = (state != S_IDLE);
  assign halted        = (state == S_HALT);
  assign console_valid = (state == S_ISSUE);
  assign console_kind  = console_valid ? kind_c : 2'd0;
  assign console_data  = console_valid ? data_c : 32'd0;

  // Decode the captured service code into the console message.
  always_comb begin
    kind_c = 2'd2;
    data_c = cap_v0;
    if (cap_v0 == 32'd1) begin
      kind_c = 2'd0;
      data_c = cap_a0;
    end else if (is_exit) begin
      kind_c = 2'd1;
      data_c = 32'd0;
    end
  end

  // Next-state logic and the redirect strobe for the upcoming IDLE entry.
  always_comb begin
    state_nxt    = state;
    redirect_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (detect) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (msg_done) begin
          if (is_exit) begin
            state_nxt = S_HALT;
          end else if (DRAIN_CYCLES == 0) begin
            state_nxt    = S_IDLE;
            redirect_set = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt    = S_IDLE;
          redirect_set = 1'b1;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, capture registers, timers and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cap_v0         <= '0;
      cap_a0         <= '0;
      cap_pc4        <= '0;
      drain_cnt      <= '0;
      wait_cnt       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      timeout_err    <= 1'b0;
      syscall_count  <= '0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= redirect_set;
      if (redirect_set) redirect_pc <= cap_pc4;
      if (detect) begin
        cap_v0  <= wb_v0;
        cap_a0  <= wb_a0;
        cap_pc4 <= wb_pc + 32'd4;
        if (syscall_count != '1) syscall_count <= syscall_count + COUNT_W'(1);
      end
      if (state != S_ISSUE)  wait_cnt <= '0;
      else if (!msg_done)    wait_cnt <= wait_cnt + TW'(1);
      if (state == S_ISSUE)                          drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN && drain_cnt != '0)  drain_cnt <= drain_cnt - DW'(1);
      if (expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Self-checking bench: three controller instances with different drain/timeout
// settings share one stimulus stream and are compared against an interval
// model of each syscall transaction.
module tb_syscall_ctrl;

  localparam int N = 3;
  localparam int DC[N] = '{2, 2, 0};
  localparam int TO[N] = '{0, 3, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wb_valid = 1'b0, wb_is_syscall = 1'b0, console_ready = 1'b0;
  logic [31:0] wb_pc = '0, wb_v0 = '0, wb_a0 = '0;

  logic        cv[N], st[N], fl[N], rv[N], hl[N], te[N];
  logic [1:0]  ck[N];
  logic [31:0] cd[N], rp[N];
  logic [15:0] sc[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    syscall_ctrl #(.DRAIN_CYCLES(DC[g]), .TIMEOUT(TO[g]), .COUNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_is_syscall(wb_is_syscall),
      .wb_pc(wb_pc), .wb_v0(wb_v0), .wb_a0(wb_a0),
      .console_ready(console_ready),
      .console_valid(cv[g]), .console_kind(ck[g]), .console_data(cd[g]),
      .stall_req(st[g]), .flush_req(fl[g]),
      .redirect_valid(rv[g]), .redirect_pc(rp[g]),
      .halted(hl[g]), .timeout_err(te[g]), .syscall_count(sc[g])
    );
  end

  int errors = 0;
  int checks = 0;

  int unsigned m_cnt[N];
  bit          m_terr[N];
  logic [31:0] m_rpc[N];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    int r;
    r = $urandom_range(0, 2);
    wb_valid      = (r == 1);
    wb_is_syscall = (r == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    wb_pc = $urandom; wb_v0 = $urandom; wb_a0 = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noise();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_terr[i] = 1'b0; m_rpc[i] = '0;
    end
  endtask

  // One syscall detected at k=0; ready held low for L ISSUE cycles.
  // chain=1 stops just before the redirect cycle so the caller can detect there.
  task automatic run_txn(input logic [2:0] mask, input logic [31:0] v0, input logic [31:0] a0,
                         input logic [31:0] pc, input int L, input bit chain, input bit prev_redir);
    int A[N]; bit drop[N]; int E[N]; int nmax;
    logic [1:0] kind; logic [31:0] data; bit ex;
    logic e_cv, e_st, e_fl, e_rv, e_hl, e_te;
    logic [1:0] e_ck; logic [31:0] e_cd, e_rp; logic [15:0] e_sc;
    ex = (v0 == 32'd10);
    if (v0 == 32'd1) begin kind = 2'd0; data = a0; end
    else if (ex)     begin kind = 2'd1; data = 32'd0; end
    else             begin kind = 2'd2; data = v0; end
    nmax = 0;
    for (int i = 0; i < N; i++) begin
      if (TO[i] > 0 && L + 1 > TO[i]) begin A[i] = TO[i]; drop[i] = 1'b1; end
      else begin A[i] = L + 1; drop[i] = 1'b0; end
      E[i] = ex ? A[i] + 3 : A[i] + DC[i] + 1;
      if (mask[i] && E[i] > nmax) nmax = E[i];
    end
    if (chain) nmax = nmax - 1;
    for (int k = 0; k <= nmax; k++) begin
      if (k == 0) begin
        wb_valid = 1'b1; wb_is_syscall = 1'b1; wb_pc = pc; wb_v0 = v0; wb_a0 = a0;
        console_ready = 1'($urandom_range(0, 1));
      end else begin
        noise();
        console_ready = (k >= L + 1);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (!mask[i]) continue;
        e_fl = (k == 0);
        e_cv = (k >= 1) && (k <= A[i]);
        e_ck = e_cv ? kind : 2'd0;
        e_cd = e_cv ? data : 32'd0;
        if (ex) begin
          e_st = (k >= 1);
          e_hl = (k >= A[i] + 1);
          e_rv = (k == 0) && prev_redir;
          e_rp = m_rpc[i];
        end else begin
          e_st = (k >= 1) && (k <= A[i] + DC[i]);
          e_hl = 1'b0;
          e_rv = (k == A[i] + DC[i] + 1) || ((k == 0) && prev_redir);
          e_rp = (k >= A[i] + DC[i] + 1) ? pc + 32'd4 : m_rpc[i];
        end
        e_te = m_terr[i] | (drop[i] && k >= A[i] + 1);
        e_sc = 16'((k >= 1 && m_cnt[i] < 65535) ? m_cnt[i] + 1 : m_cnt[i]);
        checks += 10;
        if (fl[i] !== e_fl) begin errors++; $display("FAIL flush_req inst%0d k=%0d got=%b want=%b", i, k, fl[i], e_fl); end
        if (cv[i] !== e_cv) begin errors++; $display("FAIL console_valid inst%0d k=%0d got=%b want=%b", i, k, cv[i], e_cv); end
        if (ck[i] !== e_ck) begin errors++; $display("FAIL console_kind inst%0d k=%0d got=%0d want=%0d", i, k, ck[i], e_ck); end
        if (cd[i] !== e_cd) begin errors++; $display("FAIL console_data inst%0d k=%0d got=%h want=%h", i, k, cd[i], e_cd); end
        if (st[i] !== e_st) begin errors++; $display("FAIL stall_req inst%0d k=%0d got=%b want=%b", i, k, st[i], e_st); end
        if (hl[i] !== e_hl) begin errors++; $display("FAIL halted inst%0d k=%0d got=%b want=%b", i, k, hl[i], e_hl); end
        if (rv[i] !== e_rv) begin errors++; $display("FAIL redirect_valid inst%0d k=%0d got=%b want=%b", i, k, rv[i], e_rv); end
        if (rp[i] !== e_rp) begin errors++; $display("FAIL redirect_pc inst%0d k=%0d got=%h want=%h", i, k, rp[i], e_rp); end
        if (te[i] !== e_te) begin errors++; $display("FAIL timeout_err inst%0d k=%0d got=%b want=%b", i, k, te[i], e_te); end
        if (sc[i] !== e_sc) begin errors++; $display("FAIL syscall_count inst%0d k=%0d got=%0d want=%0d", i, k, sc[i], e_sc); end
      end
      next_cycle();
    end
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) continue;
      if (m_cnt[i] < 65535) m_cnt[i]++;
      m_terr[i] |= drop[i];
      if (!ex) m_rpc[i] = pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b1; wb_is_syscall = 1'b1; console_ready = 1'b1;
    next_cycle();
    next_cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({cv[i], ck[i], cd[i], st[i], fl[i], rv[i], rp[i], hl[i], te[i], sc[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got cv=%b ck=%0d cd=%h st=%b fl=%b rv=%b rp=%h hl=%b te=%b sc=%0d want all 0",
                 i, cv[i], ck[i], cd[i], st[i], fl[i], rv[i], rp[i], hl[i], te[i], sc[i]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_terr[i] = 1'b0; m_rpc[i] = '0;
    end
  endtask

  task automatic test_print_int();
    do_reset();
    run_txn(3'b111, 32'd1, 32'hFFFF_FFFB, 32'h0040_0010, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    run_txn(3'b111, 32'd1, $urandom, 32'h0040_0100, 5, 1'b0, 1'b0);
    // Ready arriving exactly in the timeout-expiry cycle of the TIMEOUT=3 instance.
    run_txn(3'b111, 32'd2, $urandom, 32'h0040_0200, 2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    run_txn(3'b111, 32'd7, $urandom, 32'h0040_0300, 10, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] v0, pc;
    int r;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 3);
      if (r <= 1) v0 = 32'd1;
      else if (r == 2) v0 = $urandom;
      else v0 = $urandom_range(0, 20);
      if (v0 == 32'd10) v0 = 32'd11;
      pc = $urandom;
      pc[1:0] = 2'b00;
      run_txn(3'b111, v0, $urandom, pc, $urandom_range(0, 6), 1'b0, 1'b0);
    end
  endtask

  task automatic test_exit();
    do_reset();
    run_txn(3'b111, 32'd10, $urandom, 32'h0040_0400, $urandom_range(0, 4), 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      noise();
      if (k == 10 || k == 30) begin wb_valid = 1'b1; wb_is_syscall = 1'b1; end
      console_ready = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({hl[i], st[i], cv[i], rv[i], fl[i]} !== 5'b11000 || sc[i] !== 16'd1) begin
          errors++;
          $display("FAIL halt_absorbing inst%0d k=%0d got hl=%b st=%b cv=%b rv=%b fl=%b sc=%0d want 1 1 0 0 0 sc=1",
                   i, k, hl[i], st[i], cv[i], rv[i], fl[i], sc[i]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    wb_valid = 1'b1; wb_is_syscall = 1'b1; wb_v0 = 32'd1; wb_a0 = 32'h1234_5678; wb_pc = 32'h0040_0500;
    console_ready = 1'b0;
    next_cycle();
    noise(); console_ready = 1'b0;
    next_cycle();
    next_cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cv[i] !== 1'b1) begin errors++; $display("FAIL mid_issue_valid inst%0d got=%b want=1", i, cv[i]); end
    end
    rst = 1'b1;
    wb_valid = 1'b1; wb_is_syscall = 1'b1;
    next_cycle();
    rst = 1'b0;
    noise();
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({cv[i], ck[i], cd[i], st[i], fl[i], rv[i], rp[i], hl[i], te[i], sc[i]} !== '0) begin
        errors++;
        $display("FAIL reset_mid_issue inst%0d got cv=%b st=%b rv=%b hl=%b te=%b sc=%0d want all 0",
                 i, cv[i], st[i], rv[i], hl[i], te[i], sc[i]);
      end
      m_cnt[i] = 0; m_terr[i] = 1'b0; m_rpc[i] = '0;
    end
    next_cycle();
    run_txn(3'b111, 32'd1, 32'hCAFE_0001, 32'h0040_0600, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Instances 0 and 1 share timing with L<=1; instance 2 is excluded.
    run_txn(3'b011, 32'd1, $urandom, 32'h0040_0700, 1, 1'b1, 1'b0);
    run_txn(3'b011, 32'd1, $urandom, 32'hFFFF_FFFC, 0, 1'b1, 1'b1);
    run_txn(3'b011, 32'd5, $urandom, 32'h0040_0800, 1, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_print_int();
    test_backpressure();
    test_timeout();
    test_random();
    test_exit();
    test_reset_mid_issue();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syscall_ctrl.md
Name: syscall_ctrl

Overview:
- Sequences syscall handling for the 5-stage MIPS pipeline.
- Detects a valid syscall retiring in WB and flushes the younger in-flight instructions.
- Freezes the pipeline while the request goes to the console port over a valid/ready handshake, then either redirects fetch to pc+4 or halts the core permanently.
- Replaces the simulation-only print/finish behaviour in writeback with synthesizable sequencing.

Parameters:
DRAIN_CYCLES, 2, stall cycles held after console acceptance before resuming (0 allowed)
TIMEOUT, 0, max cycles waiting for console_ready; 0 = wait forever
COUNT_W, 16, width of syscall_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  WB slot holds a valid instruction
wb_is_syscall  in  1  WB instruction is a syscall
wb_pc  in  32  PC of the WB instruction
wb_v0  in  32  $v0 value (service code)
wb_a0  in  32  $a0 value (argument)
console_ready  in  1  console accepts the current message
console_valid  out  1  message valid
console_kind  out  2  0=print int, 1=exit, 2=unknown service
console_data  out  32  message payload
stall_req  out  1  freeze all stages
flush_req  out  1  kill IF/ID/EX/MEM contents
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target
halted  out  1  core terminated
timeout_err  out  1  sticky: a message was dropped on timeout
syscall_count  out  COUNT_W  syscalls accepted, saturating

Behaviour:
- States: IDLE, ISSUE, DRAIN, HALT. Reset forces IDLE from any state, including mid-handshake. On reset all outputs and counters are 0 and the captured registers are cleared.
- Detect = state==IDLE && wb_valid && wb_is_syscall. Detect is ignored in every other state.
- Detect cycle C:
  - flush_req=1, combinational, for cycle C only.
  - Capture v0, a0 and pc+4 (32-bit wrap, so 0xFFFFFFFC -> 0x00000000).
  - syscall_count+1, saturating at all-ones.
  - Next state ISSUE.
- The syscall itself retires in C; the controller does not gate its register write.
- stall_req=1 exactly when state is ISSUE, DRAIN or HALT. It is registered, not a function of the inputs.
- ISSUE:
  - console_valid=1. console_kind and console_data stay stable until accepted.
  - v0==1 -> kind 0, data=a0.
  - v0==10 -> kind 1, data=0.
  - Any other v0 -> kind 2, data=v0.
  - Acceptance happens at a rising edge with console_valid && console_ready.
  - Accepted kind 1 -> HALT. Accepted kind 0 or 2 -> DRAIN, or IDLE directly when DRAIN_CYCLES==0.
- Timeout (TIMEOUT>0 only):
  - A wait counter starts at 0 on ISSUE entry and increments each cycle without acceptance.
  - When it reaches TIMEOUT, the message is dropped, timeout_err is set, and the FSM proceeds exactly as if the message had been accepted. An exit message still goes to HALT.
  - Acceptance in the same cycle as expiry counts as acceptance; timeout_err stays 0.
- DRAIN: a down-counter loaded with DRAIN_CYCLES; it stays DRAIN_CYCLES cycles, then goes to IDLE.
- IDLE entry from DRAIN or ISSUE: redirect_valid=1 for the first IDLE cycle, registered, with redirect_pc = captured pc+4. stall_req=0 in that cycle. A detect in that cycle is legal and is processed normally.
- HALT is absorbing until rst:
  - halted=1, stall_req=1.
  - console_valid=0, redirect_valid=0, flush_req=0.
- console_valid is 0 outside ISSUE. redirect_pc holds its last value when redirect_valid=0.

Test Plan:
- Print int: v0=1, a0=0xFFFFFFFB, wb_pc=0x00400010, ready=1, DRAIN_CYCLES=2, detect at C -> flush_req only at C; console_valid at C+1 with kind 0, data 0xFFFFFFFB; stall_req C+1..C+3; redirect_valid at C+4 with redirect_pc 0x00400014; syscall_count=1.
- Backpressure: ready=0 for 5 cycles then 1 -> console_valid held 6 cycles with kind and data unchanged; exactly one acceptance.
- Exit: v0=10 -> console kind 1, data 0; halted=1 the cycle after acceptance; stall_req stays 1 for 50 cycles; a second detect pulse is ignored and syscall_count stays 1.
- Unknown and timeout: v0=7, TIMEOUT=3, ready=0 -> kind 2, data 7; timeout_err=1 after 3 cycles; DRAIN then redirect; ready rising afterwards has no effect.
- Reset mid-ISSUE: assert rst while console_valid=1 -> next cycle all outputs 0 and state IDLE; a new syscall is then handled normally.
- Back-to-back: a syscall in WB on the redirect cycle is detected and issued; wb_pc=0xFFFFFFFC gives redirect_pc=0x00000000.
